bus_distributor_1_in_n_out: RTL and testbench

BUS_DISTRIBUTOR_1_IN_N_OUT -- requirements
Module: bus_distributor_1_in_N_out

---
 rtl/bus_distributor_1_in_n_out.sv | 153 +++++++++++++++
 tb/tb_bus_distributor_1_in_n_out.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_distributor_1_in_n_out.sv
// One-input, N-output bus distributor: a small input FIFO feeds per-port
// one-entry output registers, with multicast delivery tracked per head beat.
module bus_distributor_1_in_n_out #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 ap_clk,
    input  logic                 areset_n,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0] in_dest,
    output logic                 in_ready,
    output logic [NUM_PORTS-1:0] out_valid,
    output logic [BUS_WIDTH-1:0] out_data [0:NUM_PORTS-1],
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [15:0]          drop_count,
    output logic                 busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_PAUSED   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [NUM_PORTS-1:0] mem_dest_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
    logic [BUS_WIDTH-1:0] out_data_q [NUM_PORTS];
    logic [BUS_WIDTH-1:0] out_data_d [NUM_PORTS];
    logic [15:0]          drop_count_q;

    logic                 push, pop, dispatch_en, drop_inc;
    logic [BUS_WIDTH-1:0] head_data;
    logic [NUM_PORTS-1:0] head_dest, pending, free, load;

    // Handshake, head-of-FIFO view and per-port dispatch decision
    always_comb begin
        in_ready    = areset_n & enable & (count_q < CNT_W'(FIFO_DEPTH));
        push        = in_valid & in_ready;
        head_data   = mem_data_q[rd_ptr_q];
        head_dest   = mem_dest_q[rd_ptr_q];
        pending     = head_dest & ~done_q;
        dispatch_en = (state_q == ST_DISPATCH) & enable;
        free        = ~out_valid_q | out_ready;
        load        = dispatch_en ? (pending & free) : '0;
        pop         = dispatch_en & ((pending & ~load) == '0);
        drop_inc    = pop & (head_dest == '0) & (drop_count_q != 16'hFFFF);
        count_d     = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
    end

    // Next state, delivered-port tracking and output register updates
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        out_valid_d = out_valid_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            out_data_d[i] = out_data_q[i];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = enable ? ST_DISPATCH : ST_PAUSED;
                end
            end
            ST_DISPATCH: begin
                if (!enable) begin
                    state_d = ST_PAUSED;
                end else if (pop && (count_d == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSED: begin
                if (enable) begin
                    state_d = ST_DISPATCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = pop ? '0 : (done_q | load);

        // A load wins over a consume, so back-to-back beats keep valid high
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (load[i]) begin
                out_valid_d[i] = 1'b1;
                out_data_d[i]  = head_data;
            end else if (out_valid_q[i] && out_ready[i]) begin
                out_valid_d[i] = 1'b0;
            end
        end
    end

    // Control state, FIFO and output registers
    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            done_q       <= '0;
            out_valid_q  <= '0;
            drop_count_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_dest_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                out_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                out_data_q[i] <= out_data_d[i];
            end
            if (push) begin
                mem_data_q[wr_ptr_q] <= in_data;
                mem_dest_q[wr_ptr_q] <= in_dest;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop_inc) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    // Output drive from registered state
    always_comb begin
        out_valid  = out_valid_q;
        drop_count = drop_count_q;
        busy       = (count_q != '0) | (|out_valid_q);
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            out_data[i] = out_data_q[i];
        end
    end

endmodule

// File: tb/tb_bus_distributor_1_in_n_out.sv
// Bench for the 1-in/N-out distributor: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_bus_distributor_1_in_n_out;

    localparam int unsigned NP = 2;
    localparam int unsigned BW = 8;
    localparam int unsigned FD = 2;

    localparam int M_IDLE  = 0;
    localparam int M_DISP  = 1;
    localparam int M_PAUSE = 2;

    logic          ap_clk = 1'b0;
    logic          areset_n;
    logic          enable;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic [NP-1:0] in_dest;
    logic          in_ready;
    logic [NP-1:0] out_valid;
    logic [BW-1:0] out_data [0:NP-1];
    logic [NP-1:0] out_ready;
    logic [15:0]   drop_count;
    logic          busy;

    bus_distributor_1_in_n_out #(
        .NUM_PORTS (NP),
        .BUS_WIDTH (BW),
        .FIFO_DEPTH(FD)
    ) dut (
        .ap_clk    (ap_clk),
        .areset_n  (areset_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_count(drop_count),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered beats plus per-port output holding state
    logic [BW-1:0] mq_data [$];
    logic [NP-1:0] mq_dest [$];
    int            m_state;
    logic [NP-1:0] m_done;
    logic [NP-1:0] m_ov;
    logic [BW-1:0] m_od [NP];
    logic [15:0]   m_drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        return areset_n && enable && (mq_data.size() < int'(FD));
    endfunction

    task automatic model_reset();
        mq_data.delete();
        mq_dest.delete();
        m_state = M_IDLE;
        m_done  = '0;
        m_ov    = '0;
        m_drop  = '0;
        for (int i = 0; i < int'(NP); i++) m_od[i] = '0;
    endtask

    // Apply one rising edge of the specified behaviour to the model
    task automatic model_edge();
        bit            push;
        bit            pop;
        int            cnt;
        logic [NP-1:0] pending;
        logic [NP-1:0] ld;
        logic [BW-1:0] hd;
        logic [NP-1:0] hm;
        push    = in_valid && m_in_ready();
        cnt     = mq_data.size();
        pop     = 1'b0;
        ld      = '0;
        pending = '0;
        hd      = '0;
        hm      = '0;
        if (m_state == M_DISP && enable) begin
            hd      = mq_data[0];
            hm      = mq_dest[0];
            pending = hm & ~m_done;
            for (int i = 0; i < int'(NP); i++)
                if (pending[i] && (!m_ov[i] || out_ready[i])) ld[i] = 1'b1;
            pop = ((pending & ~ld) == '0);
        end
        for (int i = 0; i < int'(NP); i++) begin
            if (ld[i]) begin
                m_ov[i] = 1'b1;
                m_od[i] = hd;
            end else if (m_ov[i] && out_ready[i]) begin
                m_ov[i] = 1'b0;
            end
        end
        if (pop) begin
            if (hm == '0 && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            void'(mq_data.pop_front());
            void'(mq_dest.pop_front());
            m_done = '0;
        end else begin
            m_done = m_done | ld;
        end
        if (push) begin
            mq_data.push_back(in_data);
            mq_dest.push_back(in_dest);
        end
        case (m_state)
            M_IDLE:  if (cnt != 0) m_state = enable ? M_DISP : M_PAUSE;
            M_DISP:  if (!enable) m_state = M_PAUSE;
                     else if (pop && mq_data.size() == 0) m_state = M_IDLE;
            default: if (enable) m_state = M_DISP;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("in_ready", 32'(in_ready), 32'(m_in_ready()));
        check_eq("out_valid", 32'(out_valid), 32'(m_ov));
        for (int i = 0; i < int'(NP); i++)
            if (m_ov[i]) check_eq($sformatf("out_data[%0d]", i), 32'(out_data[i]), 32'(m_od[i]));
        check_eq("drop_count", 32'(drop_count), 32'(m_drop));
        check_eq("busy", 32'(busy), 32'((mq_data.size() != 0) || (m_ov != '0)));
    endtask

    // Entered just after a falling edge with inputs already driven
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge ap_clk);
        if (areset_n) model_edge();
        @(negedge ap_clk);
    endtask

    task automatic send(input logic [BW-1:0] d, input logic [NP-1:0] m);
        bit acc;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = m;
        ok       = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            acc = m_in_ready();
            cycle();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("send_accepted", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic pulse_reset();
        areset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data0", 32'(out_data[0]), 32'd0);
        check_eq("rst_out_data1", 32'(out_data[1]), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_drop_count", 32'(drop_count), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge ap_clk);
        areset_n = 1'b1;
    endtask

    initial begin
        areset_n  = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        out_ready = '1;
        model_reset();
        @(negedge ap_clk);
        pulse_reset();
        run(2);

        // Unicast to port 0 from idle
        send(8'hA5, 2'b01);
        run(5);

        // Multicast with port 0 blocked, followed by a beat for port 1
        out_ready = 2'b10;
        send(8'h3C, 2'b11);
        send(8'h3D, 2'b10);
        run(2);
        out_ready = 2'b11;
        run(6);

        // Back-pressure fills output register and FIFO
        out_ready = 2'b00;
        send(8'h11, 2'b01);
        send(8'h22, 2'b01);
        send(8'h33, 2'b01);
        in_valid = 1'b1;
        in_data  = 8'h44;
        in_dest  = 2'b01;
        run(4);
        #1;
        check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        @(negedge ap_clk);
        out_ready = 2'b01;
        run(6);

        // Zero-mask drops and saturation
        out_ready = 2'b11;
        pulse_reset();
        for (int k = 0; k < 4; k++) send(8'h50 + 8'(k), 2'b00);
        run(4);
        #1;
        check_eq("drop_count_4", 32'(drop_count), 32'd4);
        @(negedge ap_clk);
        force dut.drop_count_q = 16'hFFFF;
        #1;
        release dut.drop_count_q;
        m_drop = 16'hFFFF;
        @(negedge ap_clk);
        send(8'h77, 2'b00);
        run(4);
        #1;
        check_eq("drop_count_sat", 32'(drop_count), 32'h0000FFFF);
        @(negedge ap_clk);

        // Pause with a multicast half delivered
        out_ready = 2'b01;
        send(8'h55, 2'b11);
        run(3);
        enable    = 1'b0;
        out_ready = 2'b11;
        in_valid  = 1'b1;
        in_data   = 8'h66;
        in_dest   = 2'b01;
        run(4);
        in_valid = 1'b0;
        enable   = 1'b1;
        run(5);

        // Reset with beats buffered
        out_ready = 2'b00;
        send(8'h81, 2'b01);
        send(8'h82, 2'b10);
        send(8'h83, 2'b11);
        pulse_reset();
        out_ready = 2'b11;
        run(6);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = BW'($urandom);
            in_dest   = NP'($urandom);
            out_ready = NP'($urandom);
            if (k == 1500) pulse_reset();
            cycle();
        end
        in_valid  = 1'b0;
        enable    = 1'b1;
        out_ready = '1;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
